// File: rtl/seq_value_change_checker.sv
// seq_value_change_checker
//   Synthesizable monitor for the sequence
//     rose(st) |-> rose(a) ##1 stable(b&c) ##1 fell(d)
//   Every edge samples st, a, b&c and d into history registers, starts at
//   most one new attempt and advances up to two older attempts through a
//   three-stage check pipeline. Results are registered: pass/fail pulses
//   appear in the cycle after the deciding edge, alongside saturating
//   pass/fail counters.
//
//   Optional feature, enabled by defining SEQ_CHK_FAIL_LOG_EN:
//     A free-running cycle counter plus a one-shot log of the cycle index
//     in which the first fail pulse after reset asserts. When the macro is
//     undefined, first_fail_valid and first_fail_cycle are tied to 0.
module seq_value_change_checker #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             st,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_step,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [TS_W-1:0]  first_fail_cycle
);

  // Failing-step code reported on fail_step.
  typedef enum logic [1:0] {
    STEP_NONE      = 2'd0,
    STEP_ROSE_A    = 2'd1,
    STEP_STABLE_BC = 2'd2,
    STEP_FELL_D    = 2'd3
  } step_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  // Input history: the previous edge's samples.
  logic st_q, st_d;
  logic a_q,  a_d;
  logic bc_q, bc_d;
  logic d_q,  d_d;

  // Stage-valid bits: v1 = attempt passed rose(a) last edge,
  // v2 = attempt passed stable(b&c) last edge.
  logic v1_q, v1_d;
  logic v2_q, v2_d;

  // Registered results.
  logic             pass_q,      pass_d;
  logic             fail_q,      fail_d;
  step_e            fail_step_q, fail_step_d;
  logic [CNT_W-1:0] pass_cnt_q,  pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q,  fail_cnt_d;

  // ---------------------------------------------------------------------
  // Edge-detect terms against the history registers
  // ---------------------------------------------------------------------
  logic bc;
  logic rose_st;
  logic rose_a;
  logic stable_bc;
  logic fell_d;

  assign bc        = b & c;
  assign rose_st   = st & ~st_q;
  assign rose_a    = a & ~a_q;
  assign stable_bc = (bc == bc_q);
  assign fell_d    = ~d & d_q;

  // ---------------------------------------------------------------------
  // Per-stage verdicts for this edge
  // ---------------------------------------------------------------------
  logic       start;     // new attempt begins at this edge
  logic       fail_s0;   // new attempt missed rose(a)
  logic       fail_s1;   // attempt from last edge missed stable(b&c)
  logic       fail_s2;   // attempt from two edges ago missed fell(d)
  logic       pass_s2;   // attempt from two edges ago completed
  logic [1:0] fail_num;  // failing attempts at this edge, 0..3

  // Evaluate the three in-flight stages independently.
  always_comb begin
    start    = en & rose_st;
    fail_s0  = start & ~rose_a;
    fail_s1  = v1_q & ~stable_bc;
    pass_s2  = v2_q & fell_d;
    fail_s2  = v2_q & ~fell_d;
    fail_num = {1'b0, fail_s0} + {1'b0, fail_s1} + {1'b0, fail_s2};
  end

  // ---------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------
  logic [CNT_W+1:0] fail_sum;

  // History, pipeline advance, result pulses and saturating counters.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch can be inferred.
    st_d        = st;
    a_d         = a;
    bc_d        = bc;
    d_d         = d;

    v1_d        = start & rose_a;
    v2_d        = v1_q & stable_bc;

    pass_d      = pass_s2;
    fail_d      = fail_s0 | fail_s1 | fail_s2;

    // Oldest failing attempt wins the step report.
    fail_step_d = STEP_NONE;
    if (fail_s2) begin
      fail_step_d = STEP_FELL_D;
    end else if (fail_s1) begin
      fail_step_d = STEP_STABLE_BC;
    end else if (fail_s0) begin
      fail_step_d = STEP_ROSE_A;
    end

    pass_cnt_d = pass_cnt_q;
    if (pass_s2 && (pass_cnt_q != CNT_MAX)) begin
      pass_cnt_d = pass_cnt_q + CNT_W'(1);
    end

    // Two guard bits keep the sum exact even for very narrow counters.
    fail_sum   = {2'b00, fail_cnt_q} + {{CNT_W{1'b0}}, fail_num};
    fail_cnt_d = fail_sum[CNT_W-1:0];
    if (fail_sum > {2'b00, CNT_MAX}) begin
      fail_cnt_d = CNT_MAX;
    end
  end

  // Register all checker state; reset discards in-flight attempts.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      st_q        <= 1'b0;
      a_q         <= 1'b0;
      bc_q        <= 1'b0;
      d_q         <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_step_q <= STEP_NONE;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      st_q        <= st_d;
      a_q         <= a_d;
      bc_q        <= bc_d;
      d_q         <= d_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_step_q <= fail_step_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_step = fail_step_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;

`ifdef SEQ_CHK_FAIL_LOG_EN
  // ---------------------------------------------------------------------
  // First-failure log
  // ---------------------------------------------------------------------
  logic [TS_W-1:0] ts_q,   ts_d;
  logic            ffv_q,  ffv_d;
  logic [TS_W-1:0] ffc_q,  ffc_d;

  // Free-running cycle index; capture the index of the cycle in which the
  // first fail pulse will be visible (one past the current index).
  always_comb begin
    ts_d  = ts_q + TS_W'(1);
    ffv_d = ffv_q;
    ffc_d = ffc_q;
    if (fail_d && !ffv_q) begin
      ffv_d = 1'b1;
      ffc_d = ts_d;
    end
  end

  // Register the cycle counter and the one-shot failure log.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q  <= '0;
      ffv_q <= 1'b0;
      ffc_q <= '0;
    end else begin
      ts_q  <= ts_d;
      ffv_q <= ffv_d;
      ffc_q <= ffc_d;
    end
  end

  assign first_fail_valid = ffv_q;
  assign first_fail_cycle = ffc_q;
`else
  assign first_fail_valid = 1'b0;
  assign first_fail_cycle = '0;
`endif

endmodule

// File: tb/tb_seq_value_change_checker.sv
// Testbench for seq_value_change_checker.
// A lookback model keeps the full per-edge input history and decides each
// edge's outcome by looking back at the edges where attempts could have
// started. Two DUT instances share the stimulus: a wide-counter one and a
// 2-bit-counter one that exercises saturation.
module tb_seq_value_change_checker;

  localparam int CNT_W = 16;
  localparam int SAT_W = 2;
  localparam int TS_W  = 32;
  localparam int MAXE  = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, st = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

  logic             pass, fail;
  logic [1:0]       fail_step;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic             ffv;
  logic [TS_W-1:0]  ffc;

  logic             pass_s, fail_s;
  logic [1:0]       step_s;
  logic [SAT_W-1:0] pcnt_s, fcnt_s;
  logic             ffv_s;
  logic [TS_W-1:0]  ffc_s;

  seq_value_change_checker #(.CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .st(st), .a(a), .b(b), .c(c), .d(d),
    .pass(pass), .fail(fail), .fail_step(fail_step),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(ffv), .first_fail_cycle(ffc)
  );

  seq_value_change_checker #(.CNT_W(SAT_W), .TS_W(TS_W)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .st(st), .a(a), .b(b), .c(c), .d(d),
    .pass(pass_s), .fail(fail_s), .fail_step(step_s),
    .pass_cnt(pcnt_s), .fail_cnt(fcnt_s),
    .first_fail_valid(ffv_s), .first_fail_cycle(ffc_s)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit h_st[MAXE], h_a[MAXE], h_bc[MAXE], h_d[MAXE], h_en[MAXE], h_rst[MAXE];
  int     edge_n = 0;
  int     last_rst = 0;
  bit     model_valid = 1'b0;
  bit     m_pass, m_fail, m_ffv;
  int     m_step;
  longint m_pc, m_fc, m_ffc;

  // The previous sample is meaningful only if the previous edge was not a reset.
  function automatic bit hist_ok(input int t);
    return (t > 0) && !h_rst[t-1];
  endfunction
  function automatic bit rose_st_at(input int t);
    return h_st[t] && !(hist_ok(t) && h_st[t-1]);
  endfunction
  function automatic bit rose_a_at(input int t);
    return h_a[t] && !(hist_ok(t) && h_a[t-1]);
  endfunction
  function automatic bit stable_at(input int t);
    return h_bc[t] == (hist_ok(t) ? h_bc[t-1] : 1'b0);
  endfunction
  function automatic bit fell_at(input int t);
    return !h_d[t] && hist_ok(t) && h_d[t-1];
  endfunction
  function automatic bit started_at(input int t);
    return h_en[t] && rose_st_at(t);
  endfunction
  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    int e;
    bit f1, f2, f3, p, att2, att3;
    e = edge_n;
    if (e < MAXE) begin
      h_st[e] = st; h_a[e] = a; h_bc[e] = b & c; h_d[e] = d;
      h_en[e] = en; h_rst[e] = rst;
      if (rst) begin
        m_pass = 0; m_fail = 0; m_step = 0; m_pc = 0; m_fc = 0;
        m_ffv = 0; m_ffc = 0; last_rst = e;
      end else begin
        f1   = started_at(e) && !rose_a_at(e);
        att2 = (e >= 1) && !h_rst[e-1] && started_at(e-1) && rose_a_at(e-1);
        f2   = att2 && !stable_at(e);
        att3 = (e >= 2) && !h_rst[e-2] && !h_rst[e-1] &&
               started_at(e-2) && rose_a_at(e-2) && stable_at(e-1);
        p    = att3 && fell_at(e);
        f3   = att3 && !fell_at(e);
        m_pass = p;
        m_fail = f1 || f2 || f3;
        m_step = f3 ? 3 : (f2 ? 2 : (f1 ? 1 : 0));
        m_pc  += longint'(p);
        m_fc  += longint'(f1) + longint'(f2) + longint'(f3);
        if (m_fail && !m_ffv) begin
          m_ffv = 1;
          m_ffc = longint'(e - last_rst);
        end
      end
      model_valid = 1'b1;
    end
    edge_n++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      check("pass",      pass,      m_pass);
      check("fail",      fail,      m_fail);
      check("fail_step", fail_step, m_step);
      check("pass_cnt",  pass_cnt,  sat(m_pc, CNT_W));
      check("fail_cnt",  fail_cnt,  sat(m_fc, CNT_W));
      check("sat_pass",  pass_s,    m_pass);
      check("sat_fail",  fail_s,    m_fail);
      check("sat_step",  step_s,    m_step);
      check("sat_pcnt",  pcnt_s,    sat(m_pc, SAT_W));
      check("sat_fcnt",  fcnt_s,    sat(m_fc, SAT_W));
`ifdef SEQ_CHK_FAIL_LOG_EN
      check("ff_valid",  ffv,       m_ffv);
      check("ff_cycle",  ffc,       m_ffc & 64'hFFFF_FFFF);
      check("sat_ffv",   ffv_s,     m_ffv);
`else
      check("ff_valid",  ffv,       0);
      check("ff_cycle",  ffc,       0);
      check("sat_ffv",   ffv_s,     0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Drive inputs (at a negedge), let one posedge pass, return at the next negedge.
  task automatic step(input bit i_rst, i_en, i_st, i_a, i_b, i_c, i_d);
    rst = i_rst; en = i_en; st = i_st; a = i_a; b = i_b; c = i_c; d = i_d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_pcnt", pass_cnt, 0);
    check("rst_fcnt", fail_cnt, 0);

    // Clean pass
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1, 0, 0);
    check("clean_pass", pass, 1);
    check("clean_model_pass", m_pass, 1);
    check("clean_fail", fail, 0);
    check("clean_pcnt", pass_cnt, 1);
    check("clean_fcnt", fail_cnt, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("clean_pulse_end", pass, 0);

    // Stability fail
    do_reset();
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    check("stab_fail", fail, 1);
    check("stab_step", fail_step, 2);
    check("stab_model_step", m_step, 2);
    check("stab_fcnt", fail_cnt, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("stab_no_s3_fail", fail, 0);
    check("stab_no_s3_pass", pass, 0);

    // Fell-d fail
    do_reset();
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    check("felld_fail", fail, 1);
    check("felld_step", fail_step, 3);
    check("felld_fcnt", fail_cnt, 1);

    // Overlap: A passes at the same edge B fails step 1
    do_reset();
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0);
    check("ovl_pass", pass, 1);
    check("ovl_fail", fail, 1);
    check("ovl_step", fail_step, 1);
    check("ovl_model_fcnt", m_fc, 1);
    check("ovl_pcnt", pass_cnt, 1);
    check("ovl_fcnt", fail_cnt, 1);

    // Reset in the middle of a good attempt
    do_reset();
    step(0, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 1);
    check("midrst_pass", pass, 0);
    check("midrst_pcnt", pass_cnt, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("midrst_after_pass", pass, 0);
    check("midrst_after_fail", fail, 0);

    // en low suppresses starts; held st does not re-trigger
    do_reset();
    step(0, 0, 1, 0, 0, 0, 0);
    check("en0_no_fail", fail, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("en0_no_pass", pass, 0);
    check("en0_pcnt", pass_cnt, 0);
    check("en0_fcnt", fail_cnt, 0);

    // Saturation of the 2-bit fail counter after 4 step-1 fails
    do_reset();
    step(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 0);
    end
    check("sat_fcnt_hold", fcnt_s, 3);
    check("wide_fcnt_4", fail_cnt, 4);

    // First-failure log: fail pulses in cycles 7 and 12 after reset
    step(1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, (k == 7 || k == 12), 0, 0, 0, 0);
      if (k == 7) begin
        check("fflog_fail7", fail, 1);
`ifdef SEQ_CHK_FAIL_LOG_EN
        check("fflog_valid7", ffv, 1);
        check("fflog_cycle7", ffc, 7);
        check("fflog_model7", m_ffc, 7);
`else
        check("fflog_valid7_off", ffv, 0);
        check("fflog_cycle7_off", ffc, 0);
`endif
      end
    end
    check("fflog_fail12", fail, 1);
`ifdef SEQ_CHK_FAIL_LOG_EN
    check("fflog_cycle12", ffc, 7);
`else
    check("fflog_cycle12_off", ffc, 0);
`endif

    // Randomized stimulus
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
